// File: rtl/alu_uart_interface_if.sv
// Bus between the rx/tx UART pair and the ALU consumer stage.
// The slave side is the ALU stage; the master side is whatever drives rx/tx events.
interface alu_uart_interface_if #(
  parameter int unsigned WIDTH_WORD       = 8,
  parameter int unsigned CANT_BITS_OPCODE = 6
);
  logic                        i_rx_done;
  logic [WIDTH_WORD-1:0]       i_data_rx;
  logic                        i_tx_done;
  logic                        o_tx_start;
  logic [WIDTH_WORD-1:0]       o_data_tx;
  logic [WIDTH_WORD-1:0]       o_data_a;
  logic [WIDTH_WORD-1:0]       o_data_b;
  logic [CANT_BITS_OPCODE-1:0] o_opcode;
  logic                        o_overrun;

  modport master (
    output i_rx_done, i_data_rx, i_tx_done,
    input  o_tx_start, o_data_tx, o_data_a, o_data_b, o_opcode, o_overrun
  );

  modport slave (
    input  i_rx_done, i_data_rx, i_tx_done,
    output o_tx_start, o_data_tx, o_data_a, o_data_b, o_opcode, o_overrun
  );
endinterface

// File: rtl/alu_uart_interface.sv
// Collects operand A, operand B and opcode from the rx UART, computes the ALU
// result and hands it to the tx UART with a one-cycle start pulse.
module alu_uart_interface #(
  parameter int unsigned WIDTH_WORD       = 8,
  parameter int unsigned CANT_BITS_OPCODE = 6
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  alu_uart_interface_if.slave  bus
);

  localparam logic [CANT_BITS_OPCODE-1:0] OP_ADD = CANT_BITS_OPCODE'(6'h20);
  localparam logic [CANT_BITS_OPCODE-1:0] OP_SUB = CANT_BITS_OPCODE'(6'h22);
  localparam logic [CANT_BITS_OPCODE-1:0] OP_AND = CANT_BITS_OPCODE'(6'h24);
  localparam logic [CANT_BITS_OPCODE-1:0] OP_OR  = CANT_BITS_OPCODE'(6'h25);
  localparam logic [CANT_BITS_OPCODE-1:0] OP_XOR = CANT_BITS_OPCODE'(6'h26);
  localparam logic [CANT_BITS_OPCODE-1:0] OP_NOR = CANT_BITS_OPCODE'(6'h27);
  localparam logic [CANT_BITS_OPCODE-1:0] OP_SRA = CANT_BITS_OPCODE'(6'h03);
  localparam logic [CANT_BITS_OPCODE-1:0] OP_SRL = CANT_BITS_OPCODE'(6'h02);

  typedef enum logic [2:0] {
    ST_WAIT_A,
    ST_WAIT_B,
    ST_WAIT_OP,
    ST_COMPUTE,
    ST_WAIT_TX
  } state_t;

  state_t                      state_q, state_d;
  logic                        rx_done_q, tx_done_q;
  logic [WIDTH_WORD-1:0]       data_a_q, data_a_d;
  logic [WIDTH_WORD-1:0]       data_b_q, data_b_d;
  logic [CANT_BITS_OPCODE-1:0] opcode_q, opcode_d;
  logic [WIDTH_WORD-1:0]       data_tx_q, data_tx_d;
  logic                        tx_start_q, tx_start_d;
  logic                        overrun_q, overrun_d;
  logic                        accept_c, tx_event_c;
  logic [WIDTH_WORD-1:0]       alu_c;

  // A level held for several cycles counts as a single event.
  assign accept_c   = bus.i_rx_done & ~rx_done_q;
  assign tx_event_c = bus.i_tx_done & ~tx_done_q;

  // Shift amount is the whole B word, so out-of-range shifts saturate to fill bits.
  always_comb begin
    alu_c = '0;
    case (opcode_q)
      OP_ADD: alu_c = data_a_q + data_b_q;
      OP_SUB: alu_c = data_a_q - data_b_q;
      OP_AND: alu_c = data_a_q & data_b_q;
      OP_OR:  alu_c = data_a_q | data_b_q;
      OP_XOR: alu_c = data_a_q ^ data_b_q;
      OP_NOR: alu_c = ~(data_a_q | data_b_q);
      OP_SRA: begin
        if (32'(data_b_q) >= WIDTH_WORD)
          alu_c = {WIDTH_WORD{data_a_q[WIDTH_WORD-1]}};
        else
          alu_c = WIDTH_WORD'($signed(data_a_q) >>> data_b_q);
      end
      OP_SRL: begin
        if (32'(data_b_q) >= WIDTH_WORD)
          alu_c = '0;
        else
          alu_c = data_a_q >> data_b_q;
      end
      default: alu_c = '0;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= ST_WAIT_A;
      rx_done_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      opcode_q   <= '0;
      data_tx_q  <= '0;
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_done_q  <= bus.i_rx_done;
      tx_done_q  <= bus.i_tx_done;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      opcode_q   <= opcode_d;
      data_tx_q  <= data_tx_d;
      tx_start_q <= tx_start_d;
      overrun_q  <= overrun_d;
    end
  end

  // Next-state and next-register values; tx_start defaults low so it pulses once.
  always_comb begin
    state_d    = state_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    opcode_d   = opcode_q;
    data_tx_d  = data_tx_q;
    tx_start_d = 1'b0;
    overrun_d  = overrun_q;
    case (state_q)
      ST_WAIT_A: begin
        if (accept_c) begin
          data_a_d = bus.i_data_rx;
          state_d  = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (accept_c) begin
          data_b_d = bus.i_data_rx;
          state_d  = ST_WAIT_OP;
        end
      end
      ST_WAIT_OP: begin
        if (accept_c) begin
          opcode_d = bus.i_data_rx[CANT_BITS_OPCODE-1:0];
          state_d  = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        data_tx_d  = alu_c;
        tx_start_d = 1'b1;
        state_d    = ST_WAIT_TX;
        if (accept_c) overrun_d = 1'b1;
      end
      ST_WAIT_TX: begin
        if (accept_c) overrun_d = 1'b1;
        if (tx_event_c) state_d = ST_WAIT_A;
      end
      default: state_d = ST_WAIT_A;
    endcase
  end

  assign bus.o_tx_start = tx_start_q;
  assign bus.o_data_tx  = data_tx_q;
  assign bus.o_data_a   = data_a_q;
  assign bus.o_data_b   = data_b_q;
  assign bus.o_opcode   = opcode_q;
  assign bus.o_overrun  = overrun_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Scoreboard bench for alu_uart_interface: stimulus pushes expected triples and
// results, a negedge monitor pops and compares on every tx start pulse.
module tb_alu_uart_interface;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] res;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;
  int   starts;
  int   raise_cyc;
  bit   prev_start;
  exp_t exp_q[$];

  alu_uart_interface_if #(.WIDTH_WORD(8), .CANT_BITS_OPCODE(6)) bus ();

  alu_uart_interface #(.WIDTH_WORD(8), .CANT_BITS_OPCODE(6)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: one-cycle pulse check plus scoreboard compare on every start.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_start) check("tx_start_width", 32'(bus.o_tx_start), 32'd0);
      if (bus.o_tx_start && !prev_start) begin
        starts++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_tx_start: data_tx=0x%0h with empty scoreboard", bus.o_data_tx);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("data_tx", 32'(bus.o_data_tx), 32'(e.res));
          check("data_a",  32'(bus.o_data_a),  32'(e.a));
          check("data_b",  32'(bus.o_data_b),  32'(e.b));
          check("opcode",  32'(bus.o_opcode),  32'(e.op));
          check("start_latency", 32'(cyc - raise_cyc), 32'd2);
        end
      end
      prev_start = bus.o_tx_start;
    end else begin
      prev_start = 1'b0;
    end
  end

  task automatic send_word(input logic [7:0] w, input int hold);
    @(posedge clk); #1;
    bus.i_data_rx = w;
    bus.i_rx_done = 1'b1;
    raise_cyc     = cyc;
    repeat (hold) @(posedge clk);
    #1 bus.i_rx_done = 1'b0;
  endtask

  task automatic tx_ack();
    @(posedge clk); #1 bus.i_tx_done = 1'b1;
    @(posedge clk); #1 bus.i_tx_done = 1'b0;
  endtask

  task automatic send_triple(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             input logic [7:0] res, input int hold, input bit ack);
    exp_t e;
    int   s0;
    e.a = a; e.b = b; e.op = op[5:0]; e.res = res;
    exp_q.push_back(e);
    s0 = starts;
    send_word(a, hold);
    send_word(b, hold);
    send_word(op, hold);
    for (int i = 0; i < 20 && starts == s0; i++) @(posedge clk);
    if (starts == s0) begin
      total++;
      bad++;
      $display("FAIL tx_start_timeout: no start for op=0x%0h expected 0x%0h", op, res);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    repeat (2) @(posedge clk);
    if (ack) tx_ack();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_data_a"},   32'(bus.o_data_a),   32'd0);
    check({tag, "_data_b"},   32'(bus.o_data_b),   32'd0);
    check({tag, "_opcode"},   32'(bus.o_opcode),   32'd0);
    check({tag, "_data_tx"},  32'(bus.o_data_tx),  32'd0);
    check({tag, "_tx_start"}, 32'(bus.o_tx_start), 32'd0);
    check({tag, "_overrun"},  32'(bus.o_overrun),  32'd0);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; starts = 0; raise_cyc = 0; prev_start = 1'b0;
    rst = 1'b1;
    bus.i_rx_done = 1'b0;
    bus.i_data_rx = 8'h00;
    bus.i_tx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_cleared("reset");

    // A tx_done event while waiting for A must be ignored.
    tx_ack();

    // Basic add, then the arithmetic/shift/logic set.
    send_triple(8'h05, 8'h03, 8'h20, 8'h08, 1, 1'b1);
    send_triple(8'h03, 8'h05, 8'h22, 8'hFE, 1, 1'b1);
    send_triple(8'h96, 8'h02, 8'h03, 8'hE5, 1, 1'b1);
    send_triple(8'h96, 8'h02, 8'h02, 8'h25, 1, 1'b1);
    send_triple(8'h96, 8'h0F, 8'h27, 8'h60, 1, 1'b1);

    // Long rx_done levels count once per word.
    send_triple(8'h3C, 8'h5A, 8'h26, 8'h66, 3, 1'b1);
    send_triple(8'hA5, 8'h0F, 8'h24, 8'h05, 3, 1'b1);

    check("overrun_clear", 32'(bus.o_overrun), 32'd0);

    // Word arriving while waiting on tx is dropped and flagged.
    send_triple(8'h11, 8'h22, 8'h25, 8'h33, 1, 1'b0);
    send_word(8'h77, 1);
    @(posedge clk); #1;
    check("overrun_set", 32'(bus.o_overrun), 32'd1);
    check("overrun_hold_data_tx", 32'(bus.o_data_tx), 32'h33);
    tx_ack();
    send_triple(8'h0A, 8'h01, 8'h22, 8'h09, 1, 1'b1);
    check("overrun_sticky", 32'(bus.o_overrun), 32'd1);

    // Reset in the middle of a triple discards the partial operands.
    send_word(8'h44, 1);
    send_word(8'h55, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_cleared("midreset");
    send_triple(8'h0F, 8'hF0, 8'h25, 8'hFF, 1, 1'b1);

    // Unknown opcode and oversized shifts.
    send_triple(8'h5A, 8'h33, 8'h3F, 8'h00, 1, 1'b1);
    send_triple(8'hFF, 8'h09, 8'h02, 8'h00, 1, 1'b1);
    send_triple(8'h80, 8'h09, 8'h03, 8'hFF, 1, 1'b1);
    send_triple(8'hFF, 8'h02, 8'h20, 8'h01, 1, 1'b1);

    repeat (4) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
